commit_unit: RTL and testbench

Custom-instruction commit stage. It accepts one 32-bit instruction word at a time over a valid/ready request channel and decodes the RISC-V custom-0 opcode. It then updates configuration registers or launches a peripheral run, and returns a single response over a valid/ready response channel. It sits between the instruction-issuing host and the signal-processing peripherals (AD capture, DDR, UART), which consume `cfg_a`, `cfg_b` and the `op_start`/`op_done` handshake.

---
 rtl/commit_pkg.sv | 27 ++
 rtl/commit_decoder.sv | 28 ++
 rtl/commit_unit.sv | 141 ++++++++++++++
 tb/tb_commit_unit.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// Shared constants and types for the custom-0 commit stage.
package commit_pkg;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

  localparam logic [6:0] F7_CFG_A = 7'b0000000;
  localparam logic [6:0] F7_RUN   = 7'b0100000;
  localparam logic [6:0] F7_CFG_B = 7'b0011100;

  localparam int unsigned IMM_W  = 18;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CMD_CFG_A = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_CFG_B = 2'd2,
    CMD_ERR   = 2'd3
  } cmd_e;

endpackage

// File: rtl/commit_decoder.sv
// Combinational decode of a latched instruction word into command kind and immediate.
module commit_decoder
  import commit_pkg::*;
#(
  parameter logic [6:0] OPCODE = OPCODE_CUSTOM0
) (
  input  logic [WORD_W-1:0] r_in,
  output cmd_e              cmd_c,
  output logic [IMM_W-1:0]  imm_c
);

  logic [6:0] funct7;

  always_comb begin
    funct7 = r_in[31:25];
    imm_c  = r_in[24:7];
    cmd_c  = CMD_ERR;
    if (r_in[6:0] == OPCODE) begin
      case (funct7)
        F7_CFG_A: cmd_c = CMD_CFG_A;
        F7_RUN:   cmd_c = CMD_RUN;
        F7_CFG_B: cmd_c = CMD_CFG_B;
        default:  cmd_c = CMD_ERR;
      endcase
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Custom-instruction commit stage: accepts one word, updates config or runs a peripheral, responds once.
module commit_unit
  import commit_pkg::*;
#(
  parameter logic [6:0]  OPCODE  = OPCODE_CUSTOM0,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_vaild,
  output logic              req_ready,
  input  logic [WORD_W-1:0] r_in,
  output logic              rsp_vaild,
  input  logic              rsp_ready,
  output logic              rsp_err,
  output logic [WORD_W-1:0] rsp_data,
  output logic [IMM_W-1:0]  cfg_a,
  output logic [IMM_W-1:0]  cfg_b,
  output logic              op_start,
  output logic [IMM_W-1:0]  op_len,
  input  logic              op_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q;
  logic [WORD_W-1:0]   instr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                req_ready_q;
  logic                rsp_vaild_q;
  logic                rsp_err_q;
  logic [WORD_W-1:0]   rsp_data_q;
  logic [IMM_W-1:0]    cfg_a_q;
  logic [IMM_W-1:0]    cfg_b_q;
  logic                op_start_q;
  logic [IMM_W-1:0]    op_len_q;
  cmd_e                cmd;
  logic [IMM_W-1:0]    imm;

  commit_decoder #(.OPCODE(OPCODE)) u_dec (
    .r_in  (instr_q),
    .cmd_c (cmd),
    .imm_c (imm)
  );

  // Count includes the current WAIT cycle, so the cycle op_done is sampled is counted.
  assign cnt_d = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_vaild_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      cfg_a_q     <= '0;
      cfg_b_q     <= '0;
      op_start_q  <= 1'b0;
      op_len_q    <= '0;
    end else begin
      op_start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_vaild && req_ready_q) begin
            instr_q     <= r_in;
            req_ready_q <= 1'b0;
            state_q     <= ST_EXEC;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          case (cmd)
            CMD_CFG_A: begin
              cfg_a_q     <= imm;
              rsp_data_q  <= WORD_W'(imm);
              rsp_err_q   <= 1'b0;
              rsp_vaild_q <= 1'b1;
              state_q     <= ST_RESP;
            end
            CMD_CFG_B: begin
              cfg_b_q     <= imm;
              rsp_data_q  <= WORD_W'(imm);
              rsp_err_q   <= 1'b0;
              rsp_vaild_q <= 1'b1;
              state_q     <= ST_RESP;
            end
            CMD_RUN: begin
              op_len_q   <= imm;
              op_start_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= ST_WAIT;
            end
            default: begin
              rsp_data_q  <= instr_q;
              rsp_err_q   <= 1'b1;
              rsp_vaild_q <= 1'b1;
              state_q     <= ST_RESP;
            end
          endcase
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          // Completion wins over a timeout landing on the same cycle.
          if (op_done) begin
            rsp_data_q  <= WORD_W'(cnt_d);
            rsp_err_q   <= 1'b0;
            rsp_vaild_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            rsp_data_q  <= WORD_W'(TIMEOUT);
            rsp_err_q   <= 1'b1;
            rsp_vaild_q <= 1'b1;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_vaild_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_vaild = rsp_vaild_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign cfg_a     = cfg_a_q;
  assign cfg_b     = cfg_b_q;
  assign op_start  = op_start_q;
  assign op_len    = op_len_q;

endmodule

// File: tb/tb_commit_unit.sv
// Scoreboard bench for commit_unit: random and directed commands against a decode-rule model.
module tb_commit_unit;

  localparam int unsigned TMO = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_vaild;
  logic        req_ready;
  logic [31:0] r_in;
  logic        rsp_vaild;
  logic        rsp_ready = 1'b0;
  logic        rsp_err;
  logic [31:0] rsp_data;
  logic [17:0] cfg_a;
  logic [17:0] cfg_b;
  logic        op_start;
  logic [17:0] op_len;
  logic        op_done;

  always #5 clk = ~clk;

  commit_unit #(.OPCODE(7'b0001011), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_vaild (req_vaild),
    .req_ready (req_ready),
    .r_in      (r_in),
    .rsp_vaild (rsp_vaild),
    .rsp_ready (rsp_ready),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .cfg_a     (cfg_a),
    .cfg_b     (cfg_b),
    .op_start  (op_start),
    .op_len    (op_len),
    .op_done   (op_done)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] len;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  int          accepts = 0;
  int          issued = 0;
  int          stall_req = 0;
  int unsigned m_a = 0, m_b = 0, m_len = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic bit is_run(input logic [31:0] w);
    int unsigned wu;
    wu = w;
    return (wu % 128 == 11) && ((wu >> 25) == 32);
  endfunction

  // Reference: apply decode rules to shadow registers and predict the response.
  function automatic exp_t model(input logic [31:0] w, input int d);
    exp_t        e;
    int unsigned wu, op, f7, imm;
    wu  = w;
    op  = wu % 128;
    f7  = wu >> 25;
    imm = (wu >> 7) % 262144;
    e.err  = 1'b1;
    e.data = w;
    if (op == 11) begin
      if (f7 == 0) begin
        m_a = imm; e.err = 1'b0; e.data = imm;
      end else if (f7 == 28) begin
        m_b = imm; e.err = 1'b0; e.data = imm;
      end else if (f7 == 32) begin
        m_len = imm;
        if (d >= 1 && d <= int'(TMO)) begin
          e.err = 1'b0; e.data = d;
        end else begin
          e.err = 1'b1; e.data = TMO;
        end
      end
    end
    e.a   = 18'(m_a);
    e.b   = 18'(m_b);
    e.len = 18'(m_len);
    return e;
  endfunction

  always @(posedge clk) if (!reset && req_vaild && req_ready) accepts++;

  // Monitor: pop one expectation per response, hold it stable, randomise rsp_ready.
  exp_t        mon_e;
  logic [31:0] held;
  bit          seen = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
      rsp_ready = 1'b0;
    end else if (rsp_vaild) begin
      if (!seen) begin
        if (sbq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual=%h required=none", rsp_data);
        end else begin
          mon_e = sbq.pop_front();
          chk("rsp_err", rsp_err, mon_e.err);
          chk("rsp_data", rsp_data, mon_e.data);
          chk("cfg_a", cfg_a, mon_e.a);
          chk("cfg_b", cfg_b, mon_e.b);
          chk("op_len", op_len, mon_e.len);
        end
        seen = 1'b1;
        held = rsp_data;
      end else begin
        chk("rsp_stable", rsp_data, held);
      end
      if (stall_req > 0) begin
        stall_req--;
        rsp_ready = 1'b0;
      end else begin
        rsp_ready = ($urandom_range(0, 2) != 0);
      end
      if (rsp_ready) seen = 1'b0;
    end else begin
      rsp_ready = 1'b0;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++; failures++;
        $display("FAIL req_ready_timeout actual=0 required=1");
        $fatal(1, "bench stalled");
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 || !req_ready) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        checks++; failures++;
        $display("FAIL drain_timeout actual=%0d required=0", sbq.size());
        $fatal(1, "bench stalled");
      end
    end
  endtask

  task automatic send(input logic [31:0] w, input int d, input bit early, input bit hold);
    exp_t e;
    e = model(w, d);
    sbq.push_back(e);
    issued++;
    @(negedge clk);
    req_vaild = 1'b1;
    r_in = w;
    wait_ready();
    if (hold) stall_req = 10;
    @(negedge clk);
    if (!hold) req_vaild = 1'b0;
    r_in = $urandom;
    chk("exec_rsp_vaild", rsp_vaild, 1'b0);
    chk("exec_req_ready", req_ready, 1'b0);
    op_done = early;
    @(negedge clk);
    op_done = 1'b0;
    if (!is_run(w)) begin
      chk("rsp_latency", rsp_vaild, 1'b1);
    end else begin
      chk("op_start_pulse", op_start, 1'b1);
      chk("op_len_launch", op_len, e.len);
      for (int k = 1; k <= int'(TMO); k++) begin
        if (k > 1) begin
          @(negedge clk);
          if (k == 2) chk("op_start_single", op_start, 1'b0);
          chk("wait_rsp_vaild", rsp_vaild, 1'b0);
        end
        op_done = (k == d);
        if (k == d) break;
      end
      @(negedge clk);
      op_done = 1'b0;
      chk("run_rsp_vaild", rsp_vaild, 1'b1);
    end
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        chk("bp_rsp_vaild", rsp_vaild, 1'b1);
        chk("bp_req_ready", req_ready, 1'b0);
        @(negedge clk);
      end
      req_vaild = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] w;
    int          d;
    int          kind;
    reset = 1'b1; req_vaild = 1'b0; r_in = '0; op_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_vaild", rsp_vaild, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cfg_a", cfg_a, 0);
    chk("rst_cfg_b", cfg_b, 0);
    chk("rst_op_start", op_start, 0);
    chk("rst_op_len", op_len, 0);
    reset = 1'b0;
    #1 chk("rel_req_ready_low", req_ready, 0);
    @(negedge clk);
    chk("rel_req_ready_high", req_ready, 1);

    send(32'h0054A90B, 0, 1'b0, 1'b0);
    drain();
    chk("dir_cfg_a", cfg_a, 18'h0A952);
    send(32'h4000028B, 3, 1'b1, 1'b0);
    drain();
    chk("dir_op_len", op_len, 18'd5);
    send(32'h38007F8B, 0, 1'b0, 1'b0);
    drain();
    chk("dir_cfg_b", cfg_b, 18'h000FF);
    chk("dir_cfg_a_kept", cfg_a, 18'h0A952);
    send(32'h00000033, 0, 1'b0, 1'b0);
    send(32'h4000050B, 0, 1'b0, 1'b0);
    send(32'h0000A10B, 0, 1'b0, 1'b1);
    drain();

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      w = $urandom;
      if (kind != 4) begin
        w[6:0] = 7'b0001011;
        w[31:25] = (kind == 0) ? 7'd0 : (kind == 1) ? 7'd32 : (kind == 2) ? 7'd28 : 7'($urandom);
      end
      d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO + 4);
      send(w, d, 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();

    // Reset in the middle of a RUN: no response, everything back to reset values.
    @(negedge clk);
    req_vaild = 1'b1;
    r_in = 32'h4000A28B;
    wait_ready();
    issued++;
    @(negedge clk);
    req_vaild = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    m_a = 0; m_b = 0; m_len = 0;
    #1;
    chk("midrst_rsp_vaild", rsp_vaild, 0);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_cfg_a", cfg_a, 0);
    chk("midrst_cfg_b", cfg_b, 0);
    chk("midrst_op_len", op_len, 0);
    chk("midrst_rsp_data", rsp_data, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_no_rsp", rsp_vaild, 0);
    send(32'h38000F0B, 0, 1'b0, 1'b0);
    send(32'h4000018B, 2, 1'b0, 1'b0);
    drain();

    chk("accept_count", accepts, issued);
    chk("queue_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
